// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative EX-stage multiply/divide unit.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } md_state_e;

  localparam int          MD_ITER    = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFFFFFF;

  // Magnitude of a two's-complement word; 0x80000000 maps to 2^31 read as unsigned.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the ID/EX pipeline register and ex_muldiv.
interface ex_muldiv_if;
  logic        iStart;
  logic [1:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iFlush;
  logic        oStall;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oHi;
  logic [31:0] oLo;

  modport master (
    output iStart, iOp, iA, iB, iFlush,
    input  oStall, oBusy, oDone, oHi, oLo
  );

  modport slave (
    input  iStart, iOp, iA, iB, iFlush,
    output oStall, oBusy, oDone, oHi, oLo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi,lo} accumulator: shift-add multiply or
// restoring shift-subtract divide (divide only when MULDIV_DIV_EN is defined).
module muldiv_step (
  input  logic [63:0] acc_i,
  input  logic [31:0] b_i,
  input  logic        is_div_i,
  output logic [63:0] acc_o
);

  // Multiply keeps the multiplier in the low word and shifts the 33-bit sum in from the top.
  logic [32:0] add_sum;
  assign add_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, b_i} : 33'd0);

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_sh;
  logic [32:0] diff;

  // Remainder is always below the divisor, so the shifted value fits in 33 bits
  // and diff[32] is a clean borrow flag.
  assign rem_sh = acc_i[63:31];
  assign diff   = rem_sh - {1'b0, b_i};

  always_comb begin
    if (is_div_i) begin
      acc_o = diff[32] ? {rem_sh[31:0], acc_i[30:0], 1'b0}
                       : {diff[31:0],   acc_i[30:0], 1'b1};
    end else begin
      acc_o = {add_sum, acc_i[31:1]};
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div_i;
  assign acc_o         = {add_sum, acc_i[31:1]};
`endif

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU into HI/LO, stalling ID/EX until done.
// Define MULDIV_DIV_EN to include the divide ops; otherwise DIV/DIVU are ignored.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  md
);

  localparam int                 CNT_W    = $clog2(MD_ITER);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MD_ITER - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      b_q, b_d;
  logic             q_neg_q, q_neg_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  md_op_e           op;
  logic             is_signed;
  logic             op_en;
  logic             accept;
  logic             a_neg, b_neg;
  logic [63:0]      step_acc;
  logic [63:0]      prod_fix;
  logic             step_is_div;

  assign op        = md_op_e'(md.iOp);
  assign is_signed = (op == MULT) || (op == DIV);
  assign a_neg     = is_signed & md.iA[31];
  assign b_neg     = is_signed & md.iB[31];

`ifdef MULDIV_DIV_EN
  logic is_div_q, is_div_d;
  logic r_neg_q, r_neg_d;
  logic is_div_op;
  logic div_zero;

  assign is_div_op   = (op == DIV) || (op == DIVU);
  assign div_zero    = is_div_op && (md.iB == 32'd0);
  assign op_en       = 1'b1;
  assign step_is_div = is_div_q;
`else
  assign op_en       = (op == MULT) || (op == MULTU);
  assign step_is_div = 1'b0;
`endif

  assign accept   = md.iStart & ~md.iFlush & op_en & (state_q == IDLE);
  assign prod_fix = q_neg_q ? -acc_q : acc_q;

  muldiv_step u_step (
    .acc_i    (acc_q),
    .b_i      (b_q),
    .is_div_i (step_is_div),
    .acc_o    (step_acc)
  );

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    q_neg_d = q_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    r_neg_d  = r_neg_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_DIV_EN
          if (div_zero) begin
            hi_d    = md.iA;
            lo_d    = MD_DIV0_LO;
            state_d = DONE;
          end else begin
            is_div_d = is_div_op;
            r_neg_d  = a_neg;
`else
          begin
`endif
            // Both ops start from {0, |a|}: multiplier or dividend in the low word.
            acc_d   = {32'd0, md_abs(md.iA, a_neg)};
            b_d     = md_abs(md.iB, b_neg);
            q_neg_d = a_neg ^ b_neg;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (md.iFlush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        if (md.iFlush) begin
          state_d = IDLE;
        end else begin
          state_d      = DONE;
          {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIV_EN
          // Truncating division: quotient sign from the XOR, remainder follows the dividend.
          if (is_div_q) begin
            lo_d = q_neg_q ? -acc_q[31:0]  : acc_q[31:0];
            hi_d = r_neg_q ? -acc_q[63:32] : acc_q[63:32];
          end
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      q_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      r_neg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      q_neg_q <= q_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      r_neg_q  <= r_neg_d;
`endif
    end
  end

  // The issue cycle must stall combinationally so the instruction is held in ID/EX.
  assign md.oStall = accept | (state_q == RUN) | (state_q == FIX);
  assign md.oBusy  = (state_q != IDLE);
  assign md.oDone  = (state_q == DONE);
  assign md.oHi    = hi_q;
  assign md.oLo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO queued at issue, popped at oDone.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  ex_muldiv_if md ();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sbv, q, r;
    sa  = a;
    sbv = b;
    case (op)
      2'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issues one op at the current cycle and waits for oDone; leaves the bench in the DONE cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_stall);
    int          lat;
    int          stall_cnt;
    bit          done;
    logic [63:0] want;
    md.iOp    = op;
    md.iA     = a;
    md.iB     = b;
    md.iFlush = 1'b0;
    md.iStart = 1'b1;
    #1;
    sb_q.push_back(exp);
    checks++;
    if (md.oStall !== 1'b1) begin
      errors++;
      $display("FAIL %s issue_stall got %b want 1", name, md.oStall);
    end
    lat = 0; stall_cnt = 1; done = 1'b0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      if (md.oDone === 1'b1) done = 1'b1;
      else if (md.oStall === 1'b1) stall_cnt++;
    end
    want = sb_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s done_timeout got no oDone within %0d cycles want oDone", name, lat);
    end else begin
      checks++;
      if (lat != exp_stall) begin
        errors++;
        $display("FAIL %s done_latency got T+%0d want T+%0d", name, lat, exp_stall);
      end
      checks++;
      if (stall_cnt != exp_stall) begin
        errors++;
        $display("FAIL %s stall_cycles got %0d want %0d", name, stall_cnt, exp_stall);
      end
      checks++;
      if (md.oStall !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_in_done got %b want 0", name, md.oStall);
      end
      checks++;
      if ({md.oHi, md.oLo} !== want) begin
        errors++;
        $display("FAIL %s hi_lo got %h_%h want %h_%h", name, md.oHi, md.oLo,
                 want[63:32], want[31:0]);
      end
    end
  endtask

  task automatic retire();
    md.iStart = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({md.oHi, md.oLo, md.oDone, md.oBusy, md.oStall} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state got hi=%h lo=%h done=%b busy=%b stall=%b want all 0",
               md.oHi, md.oLo, md.oDone, md.oBusy, md.oStall);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multu();
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34);
    retire();
    checks++;
    if (md.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL multu_idle_after_done busy got %b want 0", md.oBusy);
    end
  endtask

  task automatic test_mult();
    run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 34);
    retire();
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    run_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
    retire();
  endtask

  task automatic test_div_overflow();
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
    retire();
  endtask

  task automatic test_div0();
    run_op("divu_zero", DIVU, 32'h00001234, 32'd0, 64'h00001234_FFFFFFFF, 1);
    retire();
  endtask
`else
  task automatic test_div_disabled();
    for (int k = 2; k < 4; k++) begin
      md.iOp    = 2'(k);
      md.iA     = 32'd100;
      md.iB     = 32'd7;
      md.iStart = 1'b1;
      #1;
      checks++;
      if (md.oStall !== 1'b0) begin
        errors++;
        $display("FAIL div_disabled_stall op=%0d got %b want 0", k, md.oStall);
      end
      tick();
      checks++;
      if (md.oBusy !== 1'b0 || md.oDone !== 1'b0) begin
        errors++;
        $display("FAIL div_disabled_state op=%0d busy=%b done=%b want 0 0", k, md.oBusy, md.oDone);
      end
      checks++;
      if ({md.oHi, md.oLo} !== 64'hFFFFFFFF_FFFFFFF1) begin
        errors++;
        $display("FAIL div_disabled_hilo op=%0d got %h_%h want ffffffff_fffffff1", k, md.oHi, md.oLo);
      end
      retire();
    end
  endtask
`endif

  task automatic test_flush();
    logic [63:0] prior;
    bit          seen_done;
`ifdef MULDIV_DIV_EN
    prior = 64'h000000AA_000000BB;
    run_op("flush_prior", DIVU, 32'h0000BBAA, 32'h00000100, prior, 34);
`else
    prior = 64'h000000AA_00000000;
    run_op("flush_prior", MULTU, 32'h00AA0000, 32'h00010000, prior, 34);
`endif
    retire();
    md.iOp = MULTU; md.iA = 32'hFFFFFFFF; md.iB = 32'hFFFFFFFF; md.iStart = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (md.oBusy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy_before got %b want 1", md.oBusy);
    end
    md.iFlush = 1'b1;
    tick();
    md.iFlush = 1'b0;
    md.iStart = 1'b0;
    #1;
    checks++;
    if (md.oBusy !== 1'b0 || md.oStall !== 1'b0 || md.oDone !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle busy=%b stall=%b done=%b want 0 0 0", md.oBusy, md.oStall, md.oDone);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (md.oDone === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL flush_no_done got oDone pulse want none");
    end
    checks++;
    if ({md.oHi, md.oLo} !== prior) begin
      errors++;
      $display("FAIL flush_hilo got %h_%h want %h_%h", md.oHi, md.oLo, prior[63:32], prior[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    md.iOp = MULT; md.iA = 32'hFFFFFFFD; md.iB = 32'd5; md.iStart = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    md.iStart = 1'b0;
    #1;
    checks++;
    if ({md.oHi, md.oLo} !== 64'd0 || md.oBusy !== 1'b0 || md.oStall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got hi=%h lo=%h busy=%b stall=%b want 0 0 0 0",
               md.oHi, md.oLo, md.oBusy, md.oStall);
    end
    tick();
  endtask

  task automatic test_held_done();
    run_op("held_first", MULTU, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 34);
    tick();
    checks++;
    if (md.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL held_no_restart busy got %b want 0", md.oBusy);
    end
    run_op("held_next", MULTU, 32'd7, 32'd6, 64'd42, 34);
    retire();
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
`ifdef MULDIV_DIV_EN
      op = 2'($urandom_range(0, 3));
`else
      op = 2'($urandom_range(0, 1));
`endif
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op("random", op, a, b, model(op, a, b), 34);
      retire();
    end
  endtask

  initial begin
    md.iStart = 1'b0;
    md.iOp    = 2'd0;
    md.iA     = 32'd0;
    md.iB     = 32'd0;
    md.iFlush = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_multu();
    test_mult();
`ifdef MULDIV_DIV_EN
    test_div();
    test_div_overflow();
    test_div0();
`else
    test_div_disabled();
`endif
    test_flush();
    test_reset_mid();
    test_held_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative 32-bit multiply/divide unit in the EX stage, fed from the ID/EX pipeline register outputs. It computes MULT/MULTU/DIV/DIVU into HI/LO and drives the ID/EX `stall` input to hold the issuing instruction until the result is ready. A `flush` from the pipeline aborts the operation.

## Interface
- Parameters: none. Width is fixed at 32 and the iteration count at 32.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `iStart`  in  1  the instruction in ID/EX is a mul/div op (decoded from ExOp/Fun).
- `iOp`  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `iA`  in  32  rs operand (RegOut1); multiplicand or dividend.
- `iB`  in  32  rt operand (RegOut2); multiplier or divisor.
- `iFlush`  in  1  kill the current or issuing op.
- `oStall`  out  1  drives the ID/EX `stall` input.
- `oBusy`  out  1  state is not IDLE.
- `oDone`  out  1  one-cycle pulse when HI/LO have just been updated.
- `oHi`  out  32  HI register: product high word, or remainder.
- `oLo`  out  32  LO register: product low word, or quotient.

## Operation
- States are IDLE, RUN, FIX and DONE. Reset puts the block in IDLE, clears the counter, and drives `oHi`=`oLo`=0 and `oDone`=`oBusy`=0.
- **IDLE**
  - `iStart` is sampled only in this state.
  - If `iStart` & ~`iFlush` & op enabled: latch operand magnitudes (|a|, |b| for signed ops), record result-sign flags, clear the accumulator, set counter=0, go to RUN.
  - Divide by zero (`iB`=0, DIV or DIVU): go directly to DONE and load HI=`iA`, LO=0xFFFFFFFF.
- **RUN**: one radix-2 step per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - Counter increments each cycle; after step 31 (counter wraps at 31), go to FIX.
- **FIX**: apply signs and write HI/LO, then go to DONE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: the quotient is negative if the operand signs differ; the remainder takes the dividend's sign (truncating division).
  - DIV of 0x80000000 by 0xFFFFFFFF yields LO=0x80000000, HI=0 (natural 32-bit truncation). This case is not an error.
- **DONE**: `oDone`=1 and `oStall`=0, so the instruction leaves ID/EX at the end of this cycle. Go to IDLE unconditionally; `iStart` is ignored here.
- `oStall` = (IDLE & `iStart` & ~`iFlush` & op enabled) | RUN | FIX. It is combinational from `iStart` so the issue cycle is held.
- `iFlush` in RUN or FIX: go to IDLE next cycle. HI/LO are left unchanged and `oDone` does not pulse.
- `iFlush` in DONE has no effect, because HI/LO are already written.
- `rst` overrides everything, including mid-operation; HI/LO clear to 0.
- HI/LO change only on the FIX→DONE transition, the divide-by-zero IDLE→DONE transition, and reset.

## Timing
- Issue cycle T is an IDLE cycle with `iStart`=1; `oStall`=1 in T.
- RUN occupies T+1..T+32 and FIX is T+33. `oStall`=1 from T through T+33, which is 34 cycles.
- DONE is T+34: `oDone`=1, and new HI/LO are visible from T+34.
- Earliest next issue is T+35.
- Divide by zero: `oStall`=1 in T only; DONE at T+1 with HI/LO valid.
- `oBusy` = state≠IDLE, registered.

## Configuration
- `MULDIV_DIV_EN` defined: all four ops are supported.
- `MULDIV_DIV_EN` undefined:
  - The divide datapath and the divide-by-zero path are removed.
  - `iOp`=2/3 is "op not enabled": `oStall` stays 0, the state stays IDLE, and HI/LO are unchanged.
  - MULT/MULTU behave and time identically to the enabled build.

## Structure
- Package `muldiv_pkg` contains:
  - op encodings MULT/MULTU/DIV/DIVU;
  - state enum IDLE/RUN/FIX/DONE;
  - `MD_ITER`=32 and `MD_DIV0_LO`=32'hFFFFFFFF.
- One sub-module, `muldiv_step`: the combinational single-iteration shift-add / shift-subtract on the 64-bit accumulator.
- The FSM, counter, sign handling and HI/LO registers live in `ex_muldiv`.

## Test plan
- **MULTU**: `iA`=`iB`=0xFFFFFFFF at T → `oStall` high for exactly T..T+33; at T+34 `oDone`=1, HI=0xFFFFFFFE, LO=0x00000001.
- **MULT**: -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **DIV**: -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **DIV overflow**: 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **DIVU by zero**: `iA`=0x1234, `iB`=0 → `oStall` high in T only; at T+1 `oDone`=1, HI=0x1234, LO=0xFFFFFFFF.
- **Flush and reset**: prior HI/LO=0xAA/0xBB. `iFlush` at T+10 → IDLE at T+11, `oStall`=0, no `oDone`, HI/LO stay 0xAA/0xBB. Separately, `rst` at T+20 → IDLE with HI=LO=0.
- **Held instruction in DONE**: `iStart` stays high through DONE → no restart; the next issue at T+35 is accepted.
